// File: rtl/dcache_data_array.sv
// N-way line data array for the write-back D-cache: registered 1-cycle read port, whole-line fills,
// byte-strobed word stores and a post-reset clear sequencer. Define DCACHE_ARRAY_BYPASS_EN to forward same-line writes to reads.
module dcache_data_array #(
   parameter  int WAYS   = 2,
   parameter  int SETS   = 16,
   parameter  int WORDS  = 4,
   parameter  int WORD_W = 32,
   localparam int IDX_W  = $clog2(SETS),
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int LINE_W = WORDS * WORD_W,
   localparam int BE_W   = WORD_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   output logic              init_busy,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [WAY_W-1:0]  rd_way,
   output logic              rd_valid,
   output logic [LINE_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic              wr_fill,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [WAY_W-1:0]  wr_way,
   input  logic [OFF_W-1:0]  wr_offset,
   input  logic [BE_W-1:0]   wr_be,
   input  logic [WORD_W-1:0] wr_word,
   input  logic [LINE_W-1:0] wr_line,
   output logic              debug_state
);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_ptr;
   logic [LINE_W-1:0] mem [WAYS][SETS];
   logic [WAY_W-1:0]  rd_w;
   logic [WAY_W-1:0]  wr_w;
   logic [LINE_W-1:0] wr_new;
   logic              rd_bypass;

   assign debug_state = state;

   // A single way has no way bits to decode, so the field is forced to zero.
   assign rd_w = (WAYS == 1) ? '0 : rd_way;
   assign wr_w = (WAYS == 1) ? '0 : wr_way;

   always_comb begin
      wr_new = mem[wr_w][wr_index];
      if (wr_fill) begin
         wr_new = wr_line;
      end else begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               wr_new[int'(wr_offset) * WORD_W + b * 8 +: 8] = wr_word[b * 8 +: 8];
            end
         end
      end
   end

`ifdef DCACHE_ARRAY_BYPASS_EN
   assign rd_bypass = wr_en && (wr_w == rd_w) && (wr_index == rd_index);
`else
   assign rd_bypass = 1'b0;
`endif

   // Array storage: cleared one set per cycle in INIT, written by requests in READY.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == INIT) begin
            for (int w = 0; w < WAYS; w++) begin
               mem[w][clr_ptr] <= '0;
            end
         end else if (wr_en) begin
            mem[wr_w][wr_index] <= wr_new;
         end
      end
   end

   // rd_valid is a one-cycle pulse: high exactly in the cycle after an accepted rd_en;
   // there is no back-pressure, and rd_data holds its last value while rd_valid is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= INIT;
         clr_ptr   <= '0;
         init_busy <= 1'b1;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         case (state)
            INIT: begin
               rd_valid <= 1'b0;
               clr_ptr  <= clr_ptr + 1'b1;
               if (clr_ptr == IDX_W'(SETS - 1)) begin
                  state     <= READY;
                  init_busy <= 1'b0;
               end
            end
            READY: begin
               rd_valid <= rd_en;
               if (rd_en) begin
                  rd_data <= rd_bypass ? wr_new : mem[rd_w][rd_index];
               end
            end
            default: begin
               state     <= INIT;
               init_busy <= 1'b1;
               rd_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_data_array.sv
// Self-checking bench for dcache_data_array: directed scenarios plus randomized traffic against a word-level array model.
module tb_dcache_data_array;

   localparam int WAYS   = 2;
   localparam int SETS   = 16;
   localparam int WORDS  = 4;
   localparam int WORD_W = 32;
   localparam int IDX_W  = 4;
   localparam int WAY_W  = 1;
   localparam int OFF_W  = 2;
   localparam int LINE_W = WORDS * WORD_W;
   localparam int BE_W   = WORD_W / 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              init_busy;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_index;
   logic [WAY_W-1:0]  rd_way;
   logic              rd_valid;
   logic [LINE_W-1:0] rd_data;
   logic              wr_en;
   logic              wr_fill;
   logic [IDX_W-1:0]  wr_index;
   logic [WAY_W-1:0]  wr_way;
   logic [OFF_W-1:0]  wr_offset;
   logic [BE_W-1:0]   wr_be;
   logic [WORD_W-1:0] wr_word;
   logic [LINE_W-1:0] wr_line;
   logic              debug_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WORD_W-1:0] ref_w [WAYS][SETS][WORDS];
   logic [LINE_W-1:0] exp_q [$];

   // clock / reset block
   always #5 clock = ~clock;

   dcache_data_array #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .WORD_W(WORD_W)) dut (
      .clock(clock), .reset(reset), .init_busy(init_busy),
      .rd_en(rd_en), .rd_index(rd_index), .rd_way(rd_way),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_fill(wr_fill), .wr_index(wr_index), .wr_way(wr_way),
      .wr_offset(wr_offset), .wr_be(wr_be), .wr_word(wr_word), .wr_line(wr_line),
      .debug_state(debug_state)
   );

   // reference model
   function automatic logic [LINE_W-1:0] ref_line(input int way, input int set);
      logic [LINE_W-1:0] r;
      for (int i = 0; i < WORDS; i++) r[i * WORD_W +: WORD_W] = ref_w[way][set][i];
      return r;
   endfunction

   task automatic model_clear();
      for (int w = 0; w < WAYS; w++)
         for (int s = 0; s < SETS; s++)
            for (int i = 0; i < WORDS; i++) ref_w[w][s][i] = '0;
   endtask

   task automatic model_write(input logic fill, input int way, input int set, input int off,
                              input logic [BE_W-1:0] be, input logic [WORD_W-1:0] word,
                              input logic [LINE_W-1:0] line);
      if (fill) begin
         for (int i = 0; i < WORDS; i++) ref_w[way][set][i] = line[i * WORD_W +: WORD_W];
      end else begin
         for (int b = 0; b < BE_W; b++)
            if (be[b]) ref_w[way][set][off][b * 8 +: 8] = word[b * 8 +: 8];
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      rd_en = 1'b0; rd_index = '0; rd_way = '0;
      wr_en = 1'b0; wr_fill = 1'b0; wr_index = '0; wr_way = '0;
      wr_offset = '0; wr_be = '0; wr_word = '0; wr_line = '0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic drive_read(input int way, input int set);
      rd_en = 1'b1; rd_way = WAY_W'(way); rd_index = IDX_W'(set);
   endtask

   task automatic drive_fill(input int way, input int set, input logic [LINE_W-1:0] line);
      wr_en = 1'b1; wr_fill = 1'b1; wr_way = WAY_W'(way); wr_index = IDX_W'(set); wr_line = line;
      model_write(1'b1, way, set, 0, '0, '0, line);
   endtask

   task automatic drive_store(input int way, input int set, input int off,
                              input logic [BE_W-1:0] be, input logic [WORD_W-1:0] word);
      wr_en = 1'b1; wr_fill = 1'b0; wr_way = WAY_W'(way); wr_index = IDX_W'(set);
      wr_offset = OFF_W'(off); wr_be = be; wr_word = word;
      model_write(1'b0, way, set, off, be, word, '0);
   endtask

   // scenarios
   task automatic test_reset();
      int n;
      idle_inputs();
      reset = 1'b1;
      step();
      n_checks++;
      if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
      n_checks++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      n_checks++;
      if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      step();
      reset = 1'b0;
      model_clear();
      wait_init(n);
      n_checks++;
      if (n != SETS) begin n_fail++; $display("FAIL init_length: got %0d cycles expected %0d", n, SETS); end
   endtask

   task automatic test_init_zero();
      for (int k = 0; k < 8; k++) begin
         drive_read($urandom_range(0, WAYS - 1), $urandom_range(0, SETS - 1));
         step();
         rd_en = 1'b0;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL init_zero_read: got valid=%b data=%h expected valid=1 data=0", rd_valid, rd_data);
         end
      end
   endtask

   task automatic test_fill_store();
      logic [LINE_W-1:0] exp_line;
      drive_fill(1, 5, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      step();
      idle_inputs();
      drive_read(1, 5);
      step();
      rd_en = 1'b0;
      exp_line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      n_checks++;
      if (rd_data !== exp_line || rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL fill_read: got %h expected %h", rd_data, exp_line);
      end
      drive_read(0, 5);
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_data !== '0) begin n_fail++; $display("FAIL fill_other_way: got %h expected 0", rd_data); end
      drive_store(1, 5, 2, 4'b0101, 32'hAABBCCDD);
      step();
      idle_inputs();
      drive_read(1, 5);
      step();
      rd_en = 1'b0;
      exp_line = {32'h44444444, 32'h33BB33DD, 32'h22222222, 32'h11111111};
      n_checks++;
      if (rd_data !== exp_line) begin n_fail++; $display("FAIL store_merge: got %h expected %h", rd_data, exp_line); end
      n_checks++;
      if (rd_data !== ref_line(1, 5)) begin n_fail++; $display("FAIL store_model: got %h expected %h", rd_data, ref_line(1, 5)); end
   endtask

   task automatic test_valid_hold();
      logic [LINE_W-1:0] held;
      held = ref_line(1, 5);
      drive_read(1, 5);
      step();
      rd_en = 1'b0;
      step();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== held) begin
         n_fail++; $display("FAIL valid_hold: got valid=%b data=%h expected valid=0 data=%h", rd_valid, rd_data, held);
      end
   endtask

   task automatic test_same_cycle();
      logic [LINE_W-1:0] exp_line;
      drive_fill(0, 7, {4{32'hDEADBEEF}});
      step();
      idle_inputs();
`ifdef DCACHE_ARRAY_BYPASS_EN
      exp_line = '0;
`else
      exp_line = {4{32'hDEADBEEF}};
`endif
      drive_fill(0, 7, '0);
      drive_read(0, 7);
      step();
      idle_inputs();
      n_checks++;
      if (rd_data !== exp_line) begin n_fail++; $display("FAIL same_cycle_read: got %h expected %h", rd_data, exp_line); end
      drive_read(0, 7);
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_data !== '0) begin n_fail++; $display("FAIL same_cycle_after: got %h expected 0", rd_data); end
   endtask

   task automatic test_back_to_back();
      int way, set;
      for (int k = 0; k < 20; k++) begin
         way = $urandom_range(0, WAYS - 1);
         set = $urandom_range(0, SETS - 1);
         drive_read(way, set);
         exp_q.push_back(ref_line(way, set));
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
            n_fail++; $display("FAIL back_to_back: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      idle_inputs();
   endtask

   task automatic test_random();
      int rw, rs, ww, ws;
      logic do_rd;
      for (int k = 0; k < 300; k++) begin
         idle_inputs();
         do_rd = 1'($urandom_range(0, 1));
         rw = $urandom_range(0, WAYS - 1);
         rs = $urandom_range(0, 3);
         ww = $urandom_range(0, WAYS - 1);
         ws = $urandom_range(0, 3);
         if (do_rd) begin
            drive_read(rw, rs);
            exp_q.push_back(ref_line(rw, rs));
         end
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 3) == 0)
               drive_fill(ww, ws, {$urandom, $urandom, $urandom, $urandom});
            else
               drive_store(ww, ws, $urandom_range(0, WORDS - 1), BE_W'($urandom_range(0, 15)), $urandom);
         end
`ifdef DCACHE_ARRAY_BYPASS_EN
         if (do_rd) begin
            void'(exp_q.pop_back());
            exp_q.push_back(ref_line(rw, rs));
         end
`endif
         step();
         n_checks++;
         if (rd_valid !== do_rd) begin
            n_fail++; $display("FAIL random_valid: got %b expected %b", rd_valid, do_rd);
         end
         if (do_rd && exp_q.size() > 0) begin
            n_checks++;
            if (rd_data !== exp_q[0]) begin
               n_fail++; $display("FAIL random_data: got %h expected %h", rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int n;
      drive_fill(1, 3, {$urandom | 32'h1, $urandom, $urandom, $urandom});
      step();
      idle_inputs();
      drive_read(1, 3);
      reset = 1'b1;
      step();
      idle_inputs();
      reset = 1'b0;
      model_clear();
      n_checks++;
      if (rd_valid !== 1'b0 || init_busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid: got valid=%b busy=%b expected valid=0 busy=1", rd_valid, init_busy);
      end
      wait_init(n);
      n_checks++;
      if (n != SETS) begin n_fail++; $display("FAIL reset_mid_init_length: got %0d expected %0d", n, SETS); end
      drive_read(1, 3);
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== '0) begin
         n_fail++; $display("FAIL reset_mid_cleared: got valid=%b data=%h expected valid=1 data=0", rd_valid, rd_data);
      end
   endtask

   task automatic test_init_requests();
      int n;
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_clear();
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         rd_en = 1'b1; rd_way = WAY_W'($urandom_range(0, 1)); rd_index = IDX_W'($urandom_range(0, SETS - 1));
         wr_en = 1'b1; wr_fill = 1'($urandom_range(0, 1));
         wr_way = WAY_W'($urandom_range(0, 1)); wr_index = IDX_W'($urandom_range(0, SETS - 1));
         wr_offset = OFF_W'($urandom_range(0, 3)); wr_be = 4'hF;
         wr_word = $urandom | 32'h1; wr_line = {$urandom, $urandom, $urandom, $urandom | 32'h1};
         step();
         n++;
         n_checks++;
         if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL init_req_valid: got %b expected 0", rd_valid); end
      end
      idle_inputs();
      n_checks++;
      if (n != SETS) begin n_fail++; $display("FAIL init_req_length: got %0d expected %0d", n, SETS); end
      for (int w = 0; w < WAYS; w++) begin
         for (int s = 0; s < SETS; s++) begin
            drive_read(w, s);
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== ref_line(w, s)) begin
               n_fail++; $display("FAIL init_req_array way=%0d set=%0d: got %h expected %h", w, s, rd_data, ref_line(w, s));
            end
         end
      end
      idle_inputs();
      step();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_init_zero();
      test_fill_store();
      test_valid_hold();
      test_same_cycle();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_init_requests();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
